pkt_block_generator_rx: RTL and testbench

Parametrised 64b/66b test-traffic source for the RX decoder path. It emits one 66-bit block per valid cycle and builds complete packets from a start block, full data blocks, a length-dependent terminate block (T0..T7) and a run-time programmable idle gap. Payload can be a fixed character or an incrementing byte pattern, and a single-block sync-header error can be injected on demand. It sits in front of the decoder/descrambler bench chain and replaces the fixed-pattern frame generator.

---
 rtl/pcs_blocks_pkg.sv | 44 ++++
 rtl/payload_byte_gen.sv | 23 ++
 rtl/pkt_block_generator_rx.sv | 163 ++++++++++++++++
 tb/tb_pkt_block_generator_rx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_blocks_pkg.sv
// ---------------------------------------------------------------------------
// pcs_blocks_pkg
// Constants for 64b/66b block construction. The encoder, decoder and checker
// share them.
//   - sync header values (control, data, corrupted)
//   - block type bytes: IDLE, S0 and the T0..T7 terminate table
//   - IDLE_CHAR: the fixed payload byte used in fixed-character mode
//   - generator FSM state enum
// ---------------------------------------------------------------------------
package pcs_blocks_pkg;

    localparam logic [1:0] CTRL_SH = 2'b10;
    localparam logic [1:0] DATA_SH = 2'b01;
    localparam logic [1:0] ERR_SH  = 2'b00;

    localparam logic [7:0] TYPE_IDLE = 8'h1E;
    localparam logic [7:0] TYPE_S0   = 8'h78;
    localparam logic [7:0] IDLE_CHAR = 8'hFA;

    // Shortest packet that still spans a start block plus a terminate block.
    localparam int MIN_PKT_LEN = 7;

    typedef enum logic [1:0] {
        ST_GAP,
        ST_START,
        ST_DATA,
        ST_TERM
    } gen_state_t;

    // Terminate block type for k trailing data bytes.
    function automatic logic [7:0] term_type(input logic [2:0] k);
        case (k)
            3'd0:    term_type = 8'h87;
            3'd1:    term_type = 8'h99;
            3'd2:    term_type = 8'hAA;
            3'd3:    term_type = 8'hB4;
            3'd4:    term_type = 8'hCC;
            3'd5:    term_type = 8'hD2;
            3'd6:    term_type = 8'hE1;
            default: term_type = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/payload_byte_gen.sv
// ---------------------------------------------------------------------------
// payload_byte_gen
// Combinational source of 8 consecutive payload bytes.
//   base_index  in  8   index of the first byte (packet byte index mod 256)
//   mode        in  1   0 = every byte IDLE_CHAR, 1 = byte value = its index
//   bytes       out 64  byte j at [63-8j -: 8] (first byte most significant)
// ---------------------------------------------------------------------------
module payload_byte_gen
    import pcs_blocks_pkg::*;
(
    input  logic [7:0]  base_index,
    input  logic        mode,
    output logic [63:0] bytes
);

    always_comb begin
        bytes = '0;
        for (int j = 0; j < 8; j++) begin
            bytes[63-8*j -: 8] = mode ? (base_index + 8'(j)) : IDLE_CHAR;
        end
    end

endmodule

// File: rtl/pkt_block_generator_rx.sv
// ---------------------------------------------------------------------------
// pkt_block_generator_rx
// 64b/66b test-traffic source: start block, data blocks, terminate block
// T0..T7, then a programmable run of idle blocks. One block per i_valid.
//   i_clock, i_reset_n   clock, asynchronous active-low reset
//   i_enable             allow new packets to start
//   i_valid              advance one block this cycle
//   i_pkt_len            payload bytes per packet (clamped to >= 7)
//   i_ipg_blocks         idle blocks between packets (0 treated as 1)
//   i_payload_mode       0 = fixed 0xFA bytes, 1 = incrementing bytes
//   i_err_inject         corrupt the sync header of the next emitted block
//   o_data/o_valid       registered block and its valid
//   o_sop/o_eop          start / terminate block flags
//   o_pkt_count          terminate blocks emitted (wraps)
// ---------------------------------------------------------------------------
module pkt_block_generator_rx
    import pcs_blocks_pkg::*;
#(
    parameter int NB_DATA    = 66,
    parameter int NB_LEN     = 14,
    parameter int NB_IPG     = 8,
    parameter int NB_PKT_CNT = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic                  i_valid,
    input  logic [NB_LEN-1:0]     i_pkt_len,
    input  logic [NB_IPG-1:0]     i_ipg_blocks,
    input  logic                  i_payload_mode,
    input  logic                  i_err_inject,
    output logic [NB_DATA-1:0]    o_data,
    output logic                  o_valid,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic [NB_PKT_CNT-1:0] o_pkt_count
);

    localparam logic [NB_DATA-1:0] IDLE_BLOCK = {CTRL_SH, TYPE_IDLE, 56'h0};

    gen_state_t          state, state_nx, cur_state;
    logic [NB_IPG-1:0]   gap_cnt, gap_nx;
    logic [NB_LEN-1:0]   rem, rem_nx;
    logic [7:0]          byte_idx, idx_nx;
    logic                mode_q, mode_nx;
    logic                err_flag;

    logic [NB_LEN-1:0]   len_clamped, start_rem, data_rem;
    logic [7:0]          pay_base;
    logic                pay_mode;
    logic [63:0]         payload;
    logic [55:0]         term_keep;
    logic [NB_DATA-1:0]  blk_nx;
    logic                sop_nx, eop_nx;

    assign len_clamped = (i_pkt_len < NB_LEN'(MIN_PKT_LEN)) ? NB_LEN'(MIN_PKT_LEN) : i_pkt_len;
    assign start_rem   = len_clamped - NB_LEN'(MIN_PKT_LEN);
    assign data_rem    = rem - NB_LEN'(8);

    // gap_cnt holds the idle blocks still owed. A GAP cycle that owes none
    // and may launch is itself the START cycle, so the first valid cycle
    // after reset emits the start block.
    always_comb begin
        cur_state = state;
        if (state == ST_GAP && gap_cnt == '0 && i_enable) begin
            cur_state = ST_START;
        end
    end

    // The start block always begins at byte 0 with the freshly sampled mode.
    assign pay_base = (cur_state == ST_START) ? 8'd0 : byte_idx;
    assign pay_mode = (cur_state == ST_START) ? i_payload_mode : mode_q;

    payload_byte_gen u_payload_byte_gen (
        .base_index (pay_base),
        .mode       (pay_mode),
        .bytes      (payload)
    );

    // Keep the first k bytes after the terminate type, zero the rest.
    assign term_keep = ~(56'hFF_FFFF_FFFF_FFFF >> {rem[2:0], 3'b000});

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        rem_nx   = rem;
        idx_nx   = byte_idx;
        mode_nx  = mode_q;
        blk_nx   = IDLE_BLOCK;
        sop_nx   = 1'b0;
        eop_nx   = 1'b0;

        case (cur_state)
            ST_GAP: begin
                if (gap_cnt != '0) begin
                    gap_nx = gap_cnt - NB_IPG'(1);
                end
            end
            ST_START: begin
                blk_nx   = {CTRL_SH, TYPE_S0, payload[63:8]};
                sop_nx   = 1'b1;
                rem_nx   = start_rem;
                mode_nx  = i_payload_mode;
                idx_nx   = 8'(MIN_PKT_LEN);
                state_nx = (start_rem >= NB_LEN'(8)) ? ST_DATA : ST_TERM;
            end
            ST_DATA: begin
                blk_nx   = {DATA_SH, payload};
                rem_nx   = data_rem;
                idx_nx   = byte_idx + 8'd8;
                state_nx = (data_rem < NB_LEN'(8)) ? ST_TERM : ST_DATA;
            end
            ST_TERM: begin
                blk_nx   = {CTRL_SH, term_type(rem[2:0]), payload[63:8] & term_keep};
                eop_nx   = 1'b1;
                gap_nx   = (i_ipg_blocks == '0) ? NB_IPG'(1) : i_ipg_blocks;
                state_nx = ST_GAP;
            end
            default: state_nx = ST_GAP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_GAP;
            gap_cnt     <= '0;
            rem         <= '0;
            byte_idx    <= '0;
            mode_q      <= 1'b0;
            err_flag    <= 1'b0;
            o_data      <= IDLE_BLOCK;
            o_valid     <= 1'b0;
            o_sop       <= 1'b0;
            o_eop       <= 1'b0;
            o_pkt_count <= '0;
        end else if (i_valid) begin
            state    <= state_nx;
            gap_cnt  <= gap_nx;
            rem      <= rem_nx;
            byte_idx <= idx_nx;
            mode_q   <= mode_nx;
            // A pending or same-cycle injection hits this block only.
            err_flag <= 1'b0;
            o_data   <= (err_flag || i_err_inject) ? {ERR_SH, blk_nx[63:0]} : blk_nx;
            o_valid  <= 1'b1;
            o_sop    <= sop_nx;
            o_eop    <= eop_nx;
            if (eop_nx) begin
                o_pkt_count <= o_pkt_count + NB_PKT_CNT'(1);
            end
        end else begin
            o_valid <= 1'b0;
            if (i_err_inject) begin
                err_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_block_generator_rx.sv
// ---------------------------------------------------------------------------
// tb_pkt_block_generator_rx
// Directed bench for pkt_block_generator_rx. A packet-level model expands
// (length, mode, gap) into the expected block stream plus the per-block
// input settings; one compare process checks every output cycle.
// ---------------------------------------------------------------------------
module tb_pkt_block_generator_rx;

    localparam logic [65:0] IDLE_BLK = {2'b10, 8'h1E, 56'h0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_enable = 1'b1;
    logic        i_valid = 1'b0;
    logic [13:0] i_pkt_len = 14'd7;
    logic [7:0]  i_ipg_blocks = 8'd1;
    logic        i_payload_mode = 1'b0;
    logic        i_err_inject = 1'b0;
    logic [65:0] o_data;
    logic        o_valid, o_sop, o_eop;
    logic [31:0] o_pkt_count;

    always #5 clk = ~clk;

    pkt_block_generator_rx dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_enable       (i_enable),
        .i_valid        (i_valid),
        .i_pkt_len      (i_pkt_len),
        .i_ipg_blocks   (i_ipg_blocks),
        .i_payload_mode (i_payload_mode),
        .i_err_inject   (i_err_inject),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_sop          (o_sop),
        .o_eop          (o_eop),
        .o_pkt_count    (o_pkt_count)
    );

    typedef struct {
        logic [65:0] blk;
        logic        sop;
        logic        eop;
    } exp_t;

    typedef struct {
        logic [13:0] len;
        logic        mode;
        logic [7:0]  ipg;
        logic        en;
        logic        err_pre;
        logic        err_now;
    } drv_t;

    exp_t        exp_q[$];
    drv_t        drv_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_pkts = 0;
    logic [65:0] last_data = IDLE_BLK;
    logic        prev_valid;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Expand one packet plus its trailing idle gap into expected blocks and
    // the input settings to present while each block is produced.
    function automatic void add_pkt(input int len, input bit mode, input int ipg);
        int          l, p, k, nid;
        logic [7:0]  b[$];
        logic [7:0]  tt[8];
        exp_t        e;
        drv_t        d;
        tt = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        l = (len < 7) ? 7 : len;
        for (int n = 0; n < l; n++) b.push_back(mode ? 8'(n % 256) : 8'hFA);
        d.len = 14'(len); d.mode = mode; d.ipg = 8'(ipg);
        d.en = 1'b1; d.err_pre = 1'b0; d.err_now = 1'b0;

        e.blk = {2'b10, 8'h78, 56'h0};
        for (int j = 0; j < 7; j++) e.blk[55-8*j -: 8] = b[j];
        e.sop = 1'b1; e.eop = 1'b0;
        exp_q.push_back(e); drv_q.push_back(d);

        p = 7;
        while (l - p >= 8) begin
            e.blk = {2'b01, 64'h0};
            for (int j = 0; j < 8; j++) e.blk[63-8*j -: 8] = b[p+j];
            e.sop = 1'b0; e.eop = 1'b0;
            exp_q.push_back(e); drv_q.push_back(d);
            p += 8;
        end

        k = l - p;
        e.blk = {2'b10, tt[k], 56'h0};
        for (int j = 0; j < k; j++) e.blk[55-8*j -: 8] = b[p+j];
        e.sop = 1'b0; e.eop = 1'b1;
        exp_q.push_back(e); drv_q.push_back(d);

        nid = (ipg == 0) ? 1 : ipg;
        for (int i = 0; i < nid; i++) begin
            e.blk = IDLE_BLK; e.sop = 1'b0; e.eop = 1'b0;
            exp_q.push_back(e); drv_q.push_back(d);
        end
    endfunction

    function automatic void add_idles(input int n, input bit en);
        exp_t e;
        drv_t d;
        d = drv_q[drv_q.size()-1];
        d.en = en;
        e.blk = IDLE_BLK; e.sop = 1'b0; e.eop = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e); drv_q.push_back(d);
        end
    endfunction

    // Outputs are registered: o_valid follows the previous cycle's i_valid.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_valid <= 1'b0;
        else        prev_valid <= i_valid;
    end

    always @(negedge clk) begin : compare
        exp_t e;
        if (rst_n) begin
            check("o_valid", 66'(o_valid), 66'(prev_valid));
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block: got %h expected none", o_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.eop) exp_pkts++;
                    check("o_data", o_data, e.blk);
                    check("o_sop", 66'(o_sop), 66'(e.sop));
                    check("o_eop", 66'(o_eop), 66'(e.eop));
                    check("o_pkt_count", 66'(o_pkt_count), 66'(32'(exp_pkts)));
                    last_data = e.blk;
                end
            end else begin
                check("o_data_hold", o_data, last_data);
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk); #1;
        i_valid = 1'b0; i_err_inject = 1'b0; i_enable = 1'b1;
        rst_n = 1'b0;
        exp_q.delete(); drv_q.delete();
        exp_pkts = 0; last_data = IDLE_BLK;
        repeat (2) @(posedge clk);
        #1;
        check("rst_o_valid", 66'(o_valid), 66'd0);
        check("rst_o_sop", 66'(o_sop), 66'd0);
        check("rst_o_eop", 66'(o_eop), 66'd0);
        check("rst_o_pkt_count", 66'(o_pkt_count), 66'd0);
        check("rst_o_data", o_data, IDLE_BLK);
        rst_n = 1'b1;
    endtask

    // Present drv_q[0..stop-1], one per valid cycle, valid taken with pct%.
    task automatic run_stream(input int pct, input int stop, input bit drain);
        int i = 0;
        while (i < stop) begin
            @(posedge clk); #1;
            if (drv_q[i].err_pre) begin
                i_valid = 1'b0; i_err_inject = 1'b1; drv_q[i].err_pre = 1'b0;
            end else if (int'($urandom_range(99)) < pct) begin
                i_pkt_len      = drv_q[i].len;
                i_payload_mode = drv_q[i].mode;
                i_ipg_blocks   = drv_q[i].ipg;
                i_enable       = drv_q[i].en;
                i_err_inject   = drv_q[i].err_now;
                i_valid        = 1'b1;
                i++;
            end else begin
                i_valid = 1'b0; i_err_inject = 1'b0;
            end
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_err_inject = 1'b0;
        if (drain) begin
            repeat (3) @(posedge clk);
            #1;
            check("stream_drained", 66'(exp_q.size()), 66'd0);
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        reset_dut();

        // L=7, IPG=1, fixed char: S, T0, idle repeating
        for (int n = 0; n < 4; n++) add_pkt(7, 1'b0, 1);
        check("pin_s_fixed", exp_q[0].blk, 66'h2_78FAFAFAFAFAFAFA);
        check("pin_t0", exp_q[1].blk, 66'h2_8700000000000000);
        check("pin_idle", exp_q[2].blk, 66'h2_1E00000000000000);
        run_stream(100, drv_q.size(), 1'b1);
        check("count_l7", 66'(o_pkt_count), 66'd4);

        // L=20, IPG=2, incrementing bytes
        reset_dut();
        for (int n = 0; n < 2; n++) add_pkt(20, 1'b1, 2);
        check("pin_s_inc", exp_q[0].blk, 66'h2_7800010203040506);
        check("pin_d_inc", exp_q[1].blk, 66'h1_0708090A0B0C0D0E);
        check("pin_t5", exp_q[2].blk, 66'h2_D20F101112130000);
        check("pin_len20_blocks", 66'(exp_q.size()), 66'd10);
        run_stream(100, drv_q.size(), 1'b1);

        // Length sweep 7..22, clamp of short length, IPG 0, max length
        reset_dut();
        for (int l = 7; l <= 22; l++) add_pkt(l, 1'b1, 1);
        add_pkt(3, 1'b1, 0);
        add_pkt(16383, 1'b1, 0);
        add_pkt(0, 1'b0, 3);
        run_stream(100, drv_q.size(), 1'b1);
        check("count_sweep", 66'(o_pkt_count), 66'd19);

        // Enable dropped during DATA: packet completes, idles persist
        reset_dut();
        add_pkt(30, 1'b1, 1);
        check("pin_t7", exp_q[3].blk, 66'h2_FF1718191A1B1C1D);
        for (int i = 1; i <= 4; i++) drv_q[i].en = 1'b0;
        add_idles(4, 1'b0);
        add_pkt(7, 1'b0, 1);
        run_stream(100, drv_q.size(), 1'b1);

        // Sync-header error: pulse while idle-valid, and pulse on a valid cycle
        reset_dut();
        for (int n = 0; n < 3; n++) add_pkt(7, 1'b0, 1);
        drv_q[1].err_pre = 1'b1;
        exp_q[1].blk[65:64] = 2'b00;
        drv_q[4].err_now = 1'b1;
        exp_q[4].blk[65:64] = 2'b00;
        check("pin_err_blk", exp_q[1].blk, 66'h0_8700000000000000);
        run_stream(100, drv_q.size(), 1'b1);

        // Random valid, reset in the middle of a packet's DATA run
        reset_dut();
        for (int n = 0; n < 3; n++) add_pkt(30, 1'b1, 2);
        run_stream(50, 8, 1'b0);
        @(negedge clk); #1;
        check("pre_reset_consumed", 66'(exp_q.size()), 66'd10);
        reset_dut();
        for (int n = 0; n < 2; n++) add_pkt(30, 1'b1, 2);
        run_stream(50, drv_q.size(), 1'b1);
        check("count_after_reset", 66'(o_pkt_count), 66'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
